fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the cpu core. It drives word addresses to instruction memory, captures returned instructions into a small prefetch queue, and presents them to the cpu's IR load point with a valid/ready handshake.
- It accepts a redirect (branch/jump target) from the core, flushes stale work and resumes fetching at the new PC.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with prefetch queue, one outstanding imem request and redirect flush
module fetch_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, target, target_n;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count, count_n;
  logic ack, push, pop;
  assign imem_req = state != IDLE;
  assign imem_addr = fetch_pc;
  assign instr_valid = count != '0;
  assign instr = q_data[rd_ptr];
  assign instr_pc = q_pc[rd_ptr];
  assign ack = imem_req & imem_ack;
  assign push = (state == WAIT) & ack & ~redirect_valid;
  assign pop = instr_valid & instr_ready & ~redirect_valid;
  assign count_n = count + (PW+1)'(push) - (PW+1)'(pop);
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc;
    target_n = target;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          state_n = WAIT;
          fetch_pc_n = redirect_pc;
        end else if (count < FULL) state_n = WAIT;
      end
      WAIT: begin
        if (redirect_valid && !ack) begin
          state_n = DRAIN;
          target_n = redirect_pc;
        end else if (redirect_valid) fetch_pc_n = redirect_pc;
        else if (ack) begin
          fetch_pc_n = fetch_pc + 1'b1;
          state_n = count_n < FULL ? WAIT : IDLE;
        end
      end
      DRAIN: begin
        target_n = redirect_valid ? redirect_pc : target;
        if (ack) begin
          state_n = WAIT;
          fetch_pc_n = target_n;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      target <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i] <= '0;
      end
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      target <= target_n;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q_data[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr] <= fetch_pc;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count_n;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 0, rst = 1, imem_ack = 0, instr_ready = 0, redirect_valid = 0;
  logic [15:0] imem_rdata = 0, redirect_pc = 0;
  logic imem_req, instr_valid;
  logic [15:0] imem_addr, instr, instr_pc;
  int passed = 0, total = 0;
  bit auto_ack = 1;
  int lat = 0, wcnt = 0, fires = 0;
  logic last_req, last_fire;
  logic [15:0] last_addr;
  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic step();
    logic f;
    f = auto_ack && imem_req && (wcnt >= lat);
    if (auto_ack) begin
      imem_ack = f;
      imem_rdata = f ? (imem_addr ^ 16'hA000) : 16'h0000;
    end
    last_req = imem_req;
    last_fire = imem_req && imem_ack;
    last_addr = imem_addr;
    if (last_fire) fires++;
    @(posedge clk); #1;
    wcnt = (f || !last_req) ? 0 : wcnt + 1;
  endtask
  task automatic do_reset();
    rst = 1;
    redirect_valid = 0;
    auto_ack = 1;
    step();
    step();
    rst = 0;
    wcnt = 0;
    fires = 0;
  endtask
  task automatic test_reset();
    lat = 0;
    instr_ready = 1;
    do_reset();
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %h want 0", imem_req); else passed++;
    total++; if (imem_addr !== 16'h0000) $display("FAIL reset_addr got %h want 0000", imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %h want 0", instr_valid); else passed++;
    total++; if (instr !== 16'h0000) $display("FAIL reset_instr got %h want 0000", instr); else passed++;
    total++; if (instr_pc !== 16'h0000) $display("FAIL reset_pc got %h want 0000", instr_pc); else passed++;
  endtask
  task automatic test_stream();
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) $display("FAIL stream_first_req got %h/%h want 1/0000", imem_req, imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL stream_first_valid got %h want 0", instr_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (instr_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %h want 1", i, instr_valid); else passed++;
      total++; if (instr_pc !== 16'(i)) $display("FAIL stream_pc[%0d] got %h want %h", i, instr_pc, 16'(i)); else passed++;
      total++; if (instr !== (16'hA000 | 16'(i))) $display("FAIL stream_instr[%0d] got %h want %h", i, instr, 16'hA000 | 16'(i)); else passed++;
    end
  endtask
  task automatic test_backpressure();
    instr_ready = 0;
    do_reset();
    for (int i = 0; i < 9; i++) step();
    total++; if (fires !== 4) $display("FAIL bp_pushes got %0d want 4", fires); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL bp_req_stop got %h want 0", imem_req); else passed++;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) $display("FAIL bp_head got %h/%h want 1/0000", instr_valid, instr_pc); else passed++;
    instr_ready = 1;
    step();
    total++; if (instr_pc !== 16'h0001) $display("FAIL bp_pop got %h want 0001", instr_pc); else passed++;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) $display("FAIL bp_resume got %h/%h want 1/0004", imem_req, imem_addr); else passed++;
  endtask
  task automatic test_wait_states();
    int exp_pc;
    exp_pc = 0;
    lat = 3;
    instr_ready = 1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (instr_valid) begin
        total++; if (instr_pc !== 16'(exp_pc) || instr !== (16'(exp_pc) ^ 16'hA000)) $display("FAIL ws_order got %h/%h want %h/%h", instr_pc, instr, 16'(exp_pc), 16'(exp_pc) ^ 16'hA000); else passed++;
        exp_pc++;
      end
      step();
      if (last_req && !last_fire) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== last_addr) $display("FAIL ws_hold got %h/%h want 1/%h", imem_req, imem_addr, last_addr); else passed++;
      end
    end
    total++; if (exp_pc !== 7) $display("FAIL ws_count got %0d want 7", exp_pc); else passed++;
    lat = 0;
  endtask
  task automatic test_redirect_pending();
    instr_ready = 1;
    do_reset();
    auto_ack = 0;
    imem_ack = 0;
    step();
    step();
    redirect_valid = 1;
    redirect_pc = 16'h0100;
    step();
    redirect_valid = 0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) $display("FAIL drain_hold got %h/%h want 1/0000", imem_req, imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL drain_valid got %h want 0", instr_valid); else passed++;
    step();
    imem_ack = 1;
    imem_rdata = 16'hDEAD;
    step();
    imem_ack = 0;
    total++; if (instr_valid !== 1'b0) $display("FAIL drain_dead got valid %h instr %h want valid 0", instr_valid, instr); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) $display("FAIL drain_target got %h/%h want 1/0100", imem_req, imem_addr); else passed++;
    step();
    total++; if (instr_valid !== 1'b0) $display("FAIL drain_empty got %h want 0", instr_valid); else passed++;
    imem_ack = 1;
    imem_rdata = 16'h1234;
    step();
    imem_ack = 0;
    total++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h0100) $display("FAIL drain_return got %h/%h/%h want 1/1234/0100", instr_valid, instr, instr_pc); else passed++;
    auto_ack = 1;
  endtask
  task automatic test_redirect_ack_pop();
    instr_ready = 1;
    lat = 0;
    do_reset();
    step();
    step();
    step();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0001) $display("FAIL rap_pre got %h/%h want 1/0001", instr_valid, instr_pc); else passed++;
    redirect_valid = 1;
    redirect_pc = 16'h0040;
    step();
    redirect_valid = 0;
    total++; if (instr_valid !== 1'b0) $display("FAIL rap_flush got %h want 0", instr_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) $display("FAIL rap_req got %h/%h want 1/0040", imem_req, imem_addr); else passed++;
    step();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr !== 16'hA040) $display("FAIL rap_data got %h/%h/%h want 1/0040/A040", instr_valid, instr_pc, instr); else passed++;
  endtask
  task automatic test_wrap_and_reset();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
    redirect_valid = 1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 0;
    total++; if (imem_addr !== exp_addr[0]) $display("FAIL wrap_addr[0] got %h want %h", imem_addr, exp_addr[0]); else passed++;
    for (int i = 1; i < 4; i++) begin
      step();
      total++; if (imem_addr !== exp_addr[i]) $display("FAIL wrap_addr[%0d] got %h want %h", i, imem_addr, exp_addr[i]); else passed++;
      total++; if (instr_valid !== 1'b1 || instr_pc !== exp_addr[i-1]) $display("FAIL wrap_head[%0d] got %h/%h want 1/%h", i, instr_valid, instr_pc, exp_addr[i-1]); else passed++;
    end
    rst = 1;
    step();
    rst = 0;
    wcnt = 0;
    total++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) $display("FAIL midrst_req got %h/%h want 0/0000", imem_req, imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000) $display("FAIL midrst_q got %h/%h/%h want 0/0000/0000", instr_valid, instr, instr_pc); else passed++;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) $display("FAIL midrst_restart got %h/%h want 1/0000", imem_req, imem_addr); else passed++;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect_pending();
    test_redirect_ack_pop();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
